clock_divider_mc: RTL and testbench
===================================

# clock_divider_mc

Multi-channel, runtime-programmable clock divider, the parametrised successor to the fixed single-ratio divider. It generates NCH independent divided clocks from one source clock. Each channel has its own divide ratio (even or odd), an enable, and rise/fall strobes. Ratio changes are glitch-free and take effect on period boundaries, and a common sync input phase-aligns all channels. It sits beside peripheral blocks that need slow clocks or clock-enable strobes.

## Interface
- NCH, default 4: number of channels, 1..16.
- W, default 16: ratio width; maximum ratio is 2^W-1.
- DEFAULT_DIV, default 4: ratio loaded into every channel at reset, at least 2.
- clk  in  1: sole clock.
- rst  in  1: reset. Synchronous and active-high, as already decided.
- en  in  NCH: per-channel enable, level-sensitive.
- sync  in  1: restarts all enabled channels at phase 0.
- cfg_we  in  1: ratio write strobe.
- cfg_ch  in  max(1,$clog2(NCH)): target channel for the write.
- cfg_div  in  W: new ratio.
- clk_o  out  NCH: divided clocks, registered.
- rise_o  out  NCH: one-cycle strobe in the first high cycle of each clk_o period.
- fall_o  out  NCH: one-cycle strobe in the first cycle clk_o is low after being high.
- pend_o  out  NCH: a written ratio is waiting for the next period boundary.

## Operation
- Per-channel state:
  - phase counter p, 0..D-1, where D is the current ratio;
  - pending ratio plus pending flag.
- Output shape:
  - H = (D+1)>>1 and L = D>>1; clk_o=1 for p<H, otherwise 0.
  - Odd D gives a high phase one cycle longer than the low phase.
- Run: while en is high, p increments each cycle. At p=D-1 it wraps to 0, which is the period boundary.
- Ratio write (cfg_we=1):
  - cfg_div<2 is clamped to 2; cfg_ch>=NCH is ignored.
  - Disabled channel: D loads on the next edge, pend_o stays 0.
  - Enabled channel: the value is held as pending and pend_o=1. It loads at the next boundary and pend_o clears.
  - A second write before that boundary overwrites the pending value.
  - A write sampled on the boundary edge itself governs the period that starts at that edge, and pend_o never rises.
- Disable: with en sampled low, the next cycle shows p=0, clk_o=0, and the pending ratio applied. fall_o pulses once if clk_o was 1.
- Enable: en sampled high with the channel idle gives the next cycle p=0, clk_o=1, rise_o=1.
- sync: every enabled channel loads p=0 (clk_o=1, rise_o=1) and applies its pending ratio. This applies even mid-period.
- Precedence: rst > en low > sync > boundary wrap > increment. A write in the same cycle as sync is applied by that sync.
- Reset values:
  - clk_o=0, rise_o=0, fall_o=0, pend_o=0;
  - p=0 and D=DEFAULT_DIV on all channels.

## Timing
- Outputs are registered, with no combinational path from input to output.
- First divided edge: rst low and en high sampled at edge N, so clk_o=1 and rise_o=1 in cycle N+1.
- Period is exactly D cycles: rise_o pulses D cycles apart, and fall_o pulses H cycles after rise_o.
- Ratio update latency:
  - disabled channel: 1 cycle;
  - enabled channel: the remaining cycles of the current period, at most D_old.
- The period in which a ratio changes is never truncated or stretched except by sync or disable.
- There are no glitches: clk_o changes at most once per clk cycle, and only at p=0 or p=H.

## Structure
- Package clkdiv_pkg holds:
  - MIN_DIV=2;
  - the clamp function, which takes a W-bit ratio and returns it clamped to at least MIN_DIV;
  - the H/L split helper.
- Sub-module clkdiv_chan holds one channel's counter, ratio registers, output and strobe registers. The top instantiates it NCH times with a generate loop.
- The top holds the cfg_ch decode, the write-enable fan-out and the sync fan-out only.

## Test plan
- Reset release, en=all-1, D=4 → clk_o 1,1,0,0 repeating from cycle N+1, rise_o every 4 cycles, fall_o at offset 2.
- Write cfg_div=5 on channel 1 mid-period → pend_o[1]=1 until the boundary, then clk_o[1] shows 3 high and 2 low, and channel 0 is unaffected.
- Write cfg_div=0, then 1 → channel behaves as D=2 (alternating 1,0); write cfg_ch=NCH → no channel changes.
- Channels at D=3 and D=7 free-running, pulse sync → both show rise_o in the cycle after sync, then periods of 3 and 7.
- Two writes (6, then 9) before the boundary → period 9 applied, 6 never appears; a write on the boundary edge applies immediately with pend_o staying 0.
- Assert rst mid-period with a write pending → next cycle all outputs are 0, pend_o=0, and D=DEFAULT_DIV on every channel.

Source files
------------

// File: rtl/clkdiv_pkg.sv
// Shared types and helpers for the multi-channel clock divider.
// The helpers work on 32-bit values, so the ratio width W must be 32 or less.
package clkdiv_pkg;

  localparam int unsigned MIN_DIV = 2;

  // Channel run state: idle while disabled, run once the first period has started.
  typedef enum logic {
    CH_IDLE = 1'b0,
    CH_RUN  = 1'b1
  } chan_state_e;

  // Ratios below MIN_DIV cannot produce both a high and a low phase.
  function automatic logic [31:0] clamp_div(input logic [31:0] d);
    return (d < MIN_DIV) ? 32'(MIN_DIV) : d;
  endfunction

  // High-phase length H = (D+1)>>1, computed without needing a wider adder.
  function automatic logic [31:0] high_len(input logic [31:0] d);
    return (d >> 1) + {31'b0, d[0]};
  endfunction

  // Low-phase length L = D>>1.
  function automatic logic [31:0] low_len(input logic [31:0] d);
    return d >> 1;
  endfunction

endpackage

// File: rtl/clkdiv_chan.sv
// One divider channel: phase counter, active and pending ratio, registered
// clock output with rise/fall strobes.
module clkdiv_chan
  import clkdiv_pkg::*;
#(
  parameter int W           = 16,
  parameter int DEFAULT_DIV = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         en,
  input  logic         sync,
  input  logic         we,
  input  logic [W-1:0] wdiv,
  output logic         clk_o,
  output logic         rise_o,
  output logic         fall_o,
  output logic         pend_o
);

  localparam logic [W-1:0] DEF_D = W'(DEFAULT_DIV);

  chan_state_e  state, state_nxt;
  logic [W-1:0] p, p_nxt;
  logic [W-1:0] d, d_nxt;
  logic [W-1:0] pdiv, pdiv_nxt;
  logic         pend_nxt;
  logic         clk_nxt, rise_nxt, fall_nxt;
  logic [W-1:0] wdiv_c;
  logic [W-1:0] d_load;
  logic [31:0]  pinc;
  logic [31:0]  hlen;
  logic         at_wrap;
  logic         pinc_high;

  // Next-state logic; priority is disable, then restart (idle start, sync or wrap), then count.
  always_comb begin
    wdiv_c    = W'(clamp_div(32'(wdiv)));
    // A write in this same cycle beats an older pending value.
    d_load    = we ? wdiv_c : (pend_o ? pdiv : d);
    at_wrap   = (p == (d - W'(1)));
    pinc      = 32'(p) + 32'd1;
    hlen      = high_len(32'(d));
    pinc_high = (pinc < hlen);

    state_nxt = state;
    p_nxt     = p;
    d_nxt     = d;
    pdiv_nxt  = pdiv;
    pend_nxt  = pend_o;
    clk_nxt   = clk_o;
    rise_nxt  = 1'b0;
    fall_nxt  = 1'b0;

    if (!en) begin
      state_nxt = CH_IDLE;
      p_nxt     = '0;
      d_nxt     = d_load;
      pend_nxt  = 1'b0;
      clk_nxt   = 1'b0;
      fall_nxt  = clk_o;
    end else if ((state == CH_IDLE) || sync || at_wrap) begin
      // Period boundary: any new ratio governs the period starting here.
      state_nxt = CH_RUN;
      p_nxt     = '0;
      d_nxt     = d_load;
      pend_nxt  = 1'b0;
      clk_nxt   = 1'b1;
      rise_nxt  = 1'b1;
    end else begin
      p_nxt    = W'(pinc);
      clk_nxt  = pinc_high;
      fall_nxt = clk_o && !pinc_high;
      if (we) begin
        pend_nxt = 1'b1;
        pdiv_nxt = wdiv_c;
      end
    end
  end

  // Control, counter and output registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= CH_IDLE;
      p      <= '0;
      d      <= DEF_D;
      pend_o <= 1'b0;
      clk_o  <= 1'b0;
      rise_o <= 1'b0;
      fall_o <= 1'b0;
    end else begin
      state  <= state_nxt;
      p      <= p_nxt;
      d      <= d_nxt;
      pend_o <= pend_nxt;
      clk_o  <= clk_nxt;
      rise_o <= rise_nxt;
      fall_o <= fall_nxt;
    end
  end

  // Pending ratio value; only meaningful while pend_o is set.
  always_ff @(posedge clk) begin
    pdiv <= pdiv_nxt;
  end

endmodule

// File: rtl/clock_divider_mc.sv
// Multi-channel programmable clock divider: decodes the ratio write to one
// channel and fans sync out to all channels.
module clock_divider_mc
  import clkdiv_pkg::*;
#(
  parameter int NCH         = 4,
  parameter int W           = 16,
  parameter int DEFAULT_DIV = 4,
  localparam int CW         = (NCH > 1) ? $clog2(NCH) : 1
) (
  input  logic           clk,
  input  logic           rst,
  input  logic [NCH-1:0] en,
  input  logic           sync,
  input  logic           cfg_we,
  input  logic [CW-1:0]  cfg_ch,
  input  logic [W-1:0]   cfg_div,
  output logic [NCH-1:0] clk_o,
  output logic [NCH-1:0] rise_o,
  output logic [NCH-1:0] fall_o,
  output logic [NCH-1:0] pend_o
);

  logic [NCH-1:0] we_vec;

  for (genvar i = 0; i < NCH; i++) begin : g_ch
    // Out-of-range channel numbers match no channel and are dropped.
    assign we_vec[i] = cfg_we && (32'(cfg_ch) == i);

    clkdiv_chan #(
      .W           (W),
      .DEFAULT_DIV (DEFAULT_DIV)
    ) u_chan (
      .clk    (clk),
      .rst    (rst),
      .en     (en[i]),
      .sync   (sync),
      .we     (we_vec[i]),
      .wdiv   (cfg_div),
      .clk_o  (clk_o[i]),
      .rise_o (rise_o[i]),
      .fall_o (fall_o[i]),
      .pend_o (pend_o[i])
    );
  end

endmodule

// File: tb/tb_clock_divider_mc.sv
// Directed bench for clock_divider_mc (3 channels so an out-of-range cfg_ch exists).
module tb_clock_divider_mc;

  localparam int NCH = 3;
  localparam int W   = 16;
  localparam int DEF = 4;
  localparam int CW  = 2;

  logic           clk = 1'b0;
  logic           rst;
  logic [NCH-1:0] en;
  logic           sync;
  logic           cfg_we;
  logic [CW-1:0]  cfg_ch;
  logic [W-1:0]   cfg_div;
  logic [NCH-1:0] clk_o, rise_o, fall_o, pend_o;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  clock_divider_mc #(
    .NCH         (NCH),
    .W           (W),
    .DEFAULT_DIV (DEF)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .en      (en),
    .sync    (sync),
    .cfg_we  (cfg_we),
    .cfg_ch  (cfg_ch),
    .cfg_div (cfg_div),
    .clk_o   (clk_o),
    .rise_o  (rise_o),
    .fall_o  (fall_o),
    .pend_o  (pend_o)
  );

  typedef struct {
    logic [2:0]  en;
    logic        we;
    logic [1:0]  ch;
    logic [15:0] div;
    logic [2:0]  clk_e;
    logic [2:0]  rise_e;
    logic [2:0]  fall_e;
    logic [2:0]  pend_e;
  } vec_t;

  vec_t vecs[17];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [2:0] e, input logic s, input logic w,
                       input logic [1:0] ch, input logic [15:0] dv);
    en      = e;
    sync    = s;
    cfg_we  = w;
    cfg_ch  = ch;
    cfg_div = dv;
  endtask

  initial begin
    #100000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    // Free-running D=4 on all channels, then ch1 rewritten to 5 mid-period.
    vecs[0]  = '{3'b111, 1'b0, 2'd0, 16'd0, 3'b111, 3'b111, 3'b000, 3'b000};
    vecs[1]  = '{3'b111, 1'b0, 2'd0, 16'd0, 3'b111, 3'b000, 3'b000, 3'b000};
    vecs[2]  = '{3'b111, 1'b0, 2'd0, 16'd0, 3'b000, 3'b000, 3'b111, 3'b000};
    vecs[3]  = '{3'b111, 1'b0, 2'd0, 16'd0, 3'b000, 3'b000, 3'b000, 3'b000};
    vecs[4]  = '{3'b111, 1'b0, 2'd0, 16'd0, 3'b111, 3'b111, 3'b000, 3'b000};
    vecs[5]  = '{3'b111, 1'b1, 2'd1, 16'd5, 3'b111, 3'b000, 3'b000, 3'b010};
    vecs[6]  = '{3'b111, 1'b0, 2'd0, 16'd0, 3'b000, 3'b000, 3'b111, 3'b010};
    vecs[7]  = '{3'b111, 1'b0, 2'd0, 16'd0, 3'b000, 3'b000, 3'b000, 3'b010};
    vecs[8]  = '{3'b111, 1'b0, 2'd0, 16'd0, 3'b111, 3'b111, 3'b000, 3'b000};
    vecs[9]  = '{3'b111, 1'b0, 2'd0, 16'd0, 3'b111, 3'b000, 3'b000, 3'b000};
    vecs[10] = '{3'b111, 1'b0, 2'd0, 16'd0, 3'b010, 3'b000, 3'b101, 3'b000};
    vecs[11] = '{3'b111, 1'b0, 2'd0, 16'd0, 3'b000, 3'b000, 3'b010, 3'b000};
    vecs[12] = '{3'b111, 1'b0, 2'd0, 16'd0, 3'b101, 3'b101, 3'b000, 3'b000};
    vecs[13] = '{3'b111, 1'b0, 2'd0, 16'd0, 3'b111, 3'b010, 3'b000, 3'b000};
    vecs[14] = '{3'b111, 1'b0, 2'd0, 16'd0, 3'b010, 3'b000, 3'b101, 3'b000};
    vecs[15] = '{3'b111, 1'b0, 2'd0, 16'd0, 3'b010, 3'b000, 3'b000, 3'b000};
    vecs[16] = '{3'b111, 1'b0, 2'd0, 16'd0, 3'b101, 3'b101, 3'b010, 3'b000};

    // Reset state
    rst = 1'b1;
    drive(3'b000, 1'b0, 1'b0, 2'd0, 16'd0);
    tick();
    tick();
    chk("reset clk_o", clk_o, 0);
    chk("reset rise_o", rise_o, 0);
    chk("reset fall_o", fall_o, 0);
    chk("reset pend_o", pend_o, 0);

    // Table: release reset with all enabled, then mid-period write on ch1
    rst = 1'b0;
    for (int i = 0; i < 17; i++) begin
      drive(vecs[i].en, 1'b0, vecs[i].we, vecs[i].ch, vecs[i].div);
      tick();
      chk($sformatf("vec%0d clk_o", i), clk_o, vecs[i].clk_e);
      chk($sformatf("vec%0d rise_o", i), rise_o, vecs[i].rise_e);
      chk($sformatf("vec%0d fall_o", i), fall_o, vecs[i].fall_e);
      chk($sformatf("vec%0d pend_o", i), pend_o, vecs[i].pend_e);
    end

    // Clamp: disabled ch2 gets 0 then 1, runs as D=2
    drive(3'b011, 1'b0, 1'b1, 2'd2, 16'd0);
    tick();
    chk("dis clk2", clk_o[2], 0);
    chk("dis fall2", fall_o[2], 1);
    chk("dis pend2", pend_o[2], 0);
    drive(3'b011, 1'b0, 1'b1, 2'd2, 16'd1);
    tick();
    chk("dis2 clk2", clk_o[2], 0);
    chk("dis2 fall2", fall_o[2], 0);
    chk("dis2 pend2", pend_o[2], 0);
    drive(3'b111, 1'b0, 1'b0, 2'd0, 16'd0);
    tick();
    chk("d2 start clk2", clk_o[2], 1);
    chk("d2 start rise2", rise_o[2], 1);
    tick();
    chk("d2 low clk2", clk_o[2], 0);
    chk("d2 low fall2", fall_o[2], 1);
    tick();
    chk("d2 high clk2", clk_o[2], 1);
    chk("d2 high rise2", rise_o[2], 1);
    // Out-of-range channel write touches nothing
    drive(3'b111, 1'b0, 1'b1, 2'd3, 16'd9);
    tick();
    chk("badch clk2", clk_o[2], 0);
    chk("badch pend", pend_o, 0);
    drive(3'b111, 1'b0, 1'b0, 2'd0, 16'd0);
    tick();
    chk("badch2 clk2", clk_o[2], 1);
    chk("badch2 pend", pend_o, 0);

    // Sync: ch0 at D=3, ch1 at D=7
    drive(3'b100, 1'b0, 1'b1, 2'd0, 16'd3);
    tick();
    drive(3'b100, 1'b0, 1'b1, 2'd1, 16'd7);
    tick();
    drive(3'b111, 1'b0, 1'b0, 2'd0, 16'd0);
    tick();
    chk("c start rise0", rise_o[0], 1);
    chk("c start rise1", rise_o[1], 1);
    tick();
    tick();
    tick();
    chk("c d3 wrap rise0", rise_o[0], 1);
    chk("c d3 wrap rise1", rise_o[1], 0);
    drive(3'b111, 1'b1, 1'b0, 2'd0, 16'd0);
    tick();
    chk("sync rise0", rise_o[0], 1);
    chk("sync rise1", rise_o[1], 1);
    chk("sync clk0", clk_o[0], 1);
    chk("sync clk1", clk_o[1], 1);
    drive(3'b111, 1'b0, 1'b0, 2'd0, 16'd0);
    for (int k = 1; k <= 8; k++) begin
      tick();
      chk($sformatf("post sync k%0d rise0", k), rise_o[0], 32'((k % 3) == 0));
      chk($sformatf("post sync k%0d clk0", k), clk_o[0], 32'((k % 3) < 2));
      chk($sformatf("post sync k%0d rise1", k), rise_o[1], 32'((k % 7) == 0));
      chk($sformatf("post sync k%0d clk1", k), clk_o[1], 32'((k % 7) < 4));
    end

    // Double write before the boundary on ch0 (D=3, now at p=2)
    tick();
    chk("dw wrap rise0", rise_o[0], 1);
    drive(3'b111, 1'b0, 1'b1, 2'd0, 16'd6);
    tick();
    chk("dw first pend0", pend_o[0], 1);
    drive(3'b111, 1'b0, 1'b1, 2'd0, 16'd9);
    tick();
    chk("dw second pend0", pend_o[0], 1);
    chk("dw second clk0", clk_o[0], 0);
    drive(3'b111, 1'b0, 1'b0, 2'd0, 16'd0);
    tick();
    chk("dw load rise0", rise_o[0], 1);
    chk("dw load pend0", pend_o[0], 0);
    for (int k = 1; k <= 9; k++) begin
      // Write landing on the wrap edge governs the new period directly
      if (k == 9) drive(3'b111, 1'b0, 1'b1, 2'd0, 16'd5);
      else        drive(3'b111, 1'b0, 1'b0, 2'd0, 16'd0);
      tick();
      chk($sformatf("d9 k%0d rise0", k), rise_o[0], 32'(k == 9));
      chk($sformatf("d9 k%0d clk0", k), clk_o[0], 32'((k % 9) < 5));
      chk($sformatf("d9 k%0d pend0", k), pend_o[0], 0);
    end
    drive(3'b111, 1'b0, 1'b0, 2'd0, 16'd0);
    for (int k = 1; k <= 5; k++) begin
      tick();
      chk($sformatf("d5 k%0d rise0", k), rise_o[0], 32'(k == 5));
      chk($sformatf("d5 k%0d clk0", k), clk_o[0], 32'((k % 5) < 3));
      chk($sformatf("d5 k%0d pend0", k), pend_o[0], 0);
    end

    // Reset mid-period with a write pending on ch1 (D=7, p=5)
    drive(3'b111, 1'b0, 1'b1, 2'd1, 16'd10);
    tick();
    chk("rst pre pend1", pend_o[1], 1);
    drive(3'b111, 1'b0, 1'b0, 2'd0, 16'd0);
    rst = 1'b1;
    tick();
    chk("rst mid clk_o", clk_o, 0);
    chk("rst mid rise_o", rise_o, 0);
    chk("rst mid fall_o", fall_o, 0);
    chk("rst mid pend_o", pend_o, 0);
    rst = 1'b0;
    for (int k = 1; k <= 8; k++) begin
      tick();
      chk($sformatf("rel k%0d clk_o", k), clk_o, ((k - 1) % 4) < 2 ? 32'h7 : 32'h0);
      chk($sformatf("rel k%0d rise_o", k), rise_o, ((k - 1) % 4) == 0 ? 32'h7 : 32'h0);
      chk($sformatf("rel k%0d fall_o", k), fall_o, ((k - 1) % 4) == 2 ? 32'h7 : 32'h0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
